data_mem_requester: RTL

//  Initiator side of the data-memory port. Takes load/store requests from the pipeline over a valid/ready

---
 rtl/data_mem_requester.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/data_mem_requester.sv
// Initiator for a data memory with a registered one-edge read: accepts one load/store at a time,
// drives the memory control signals and returns load data, a store ack or an address error.
module data_mem_requester #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DEPTH  = 9
) (
  input  logic                  Clock,
  input  logic                  Clear,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqWrite,
  input  logic [ADDR_WIDTH-1:0] ReqAddr,
  input  logic [DATA_WIDTH-1:0] ReqData,
  output logic                  RspValid,
  input  logic                  RspReady,
  output logic [DATA_WIDTH-1:0] RspData,
  output logic                  RspError,
  output logic [ADDR_WIDTH-1:0] Addr,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  MemWrite,
  output logic                  MemRead,
  input  logic [DATA_WIDTH-1:0] MemData,
  output logic                  Busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [ADDR_WIDTH-1:0] DepthAddr = ADDR_WIDTH'(MEM_DEPTH);

  state_t                state_q, state_d;
  logic                  req_write_q, req_write_d;
  logic                  req_ready_q, req_ready_d;
  logic                  busy_q, busy_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_error_q, rsp_error_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  mem_write_q, mem_write_d;
  logic                  mem_read_q, mem_read_d;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    req_write_d = req_write_q;
    rsp_valid_d = rsp_valid_q;
    rsp_error_d = rsp_error_q;
    rsp_data_d  = rsp_data_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_write_d = 1'b0;
    mem_read_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (ReqValid && req_ready_q) begin
          req_write_d = ReqWrite;
          if (ReqAddr >= DepthAddr) begin
            rsp_error_d = 1'b1;
            rsp_data_d  = '0;
            state_d     = RESP;
          end else begin
            addr_d = ReqAddr;
            if (ReqWrite) begin
              wdata_d     = ReqData;
              mem_write_d = 1'b1;
            end else begin
              mem_read_d = 1'b1;
            end
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (req_write_q) begin
          rsp_data_d  = '0;
          rsp_error_d = 1'b0;
          state_d     = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // MemData still carries the read word just before this edge.
        rsp_data_d  = MemData;
        rsp_error_d = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end else if (RspReady) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q     <= IDLE;
      req_write_q <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_data_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_write_q <= req_write_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_data_q  <= rsp_data_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_write_q <= mem_write_d;
      mem_read_q  <= mem_read_d;
    end
  end

  assign ReqReady  = req_ready_q;
  assign Busy      = busy_q;
  assign RspValid  = rsp_valid_q;
  assign RspError  = rsp_error_q;
  assign RspData   = rsp_data_q;
  assign Addr      = addr_q;
  assign WriteData = wdata_q;
  assign MemWrite  = mem_write_q;
  assign MemRead   = mem_read_q;

endmodule
